booth_ctrl: RTL and testbench

Control unit for the radix-2 Booth sequential multiplier. It sequences the accumulator register (A), multiplier register (Q plus the Q[-1] bit) and multiplicand register (M). It issues the load, shift and clear strobes that those registers consume, and selects add or subtract in the adder/subtractor. It sits on the initiating side of the register control interface, drives every strobe for one operation from a single `start` request, and reports completion with `fin`.

---
 rtl/booth_ctrl.sv | 145 ++++++++++++++
 tb/tb_booth_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_ctrl.sv
// booth_ctrl: control unit for a radix-2 Booth sequential multiplier.
// Sequences the A (accumulator), Q/Q[-1] (multiplier) and M (multiplicand)
// registers through N Booth iterations from a single start request.
// Moore machine: every strobe is decoded from the registered state alone,
// so an asynchronous reset clears all outputs without waiting for a clock.

module booth_ctrl #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic q0,
    input  logic qm1,
    output logic ResetA,
    output logic CargaA,
    output logic DesplazaA,
    output logic CargaQ,
    output logic DesplazaQ,
    output logic CargaM,
    output logic SumaResta,
    output logic busy,
    output logic fin
);

    // Counter wide enough to hold the value N itself.
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LP_LAST = CW'(N);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SUB   = 3'd4,
        S_SHIFT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_last_iter;

    // The SHIFT state ends the current iteration; the incremented count
    // decides whether that was the last one.
    assign w_cnt_inc   = r_cnt + CW'(1);
    assign w_last_iter = (w_cnt_inc == LP_LAST);

    // State register with asynchronous active-low reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values; blocking (=) here would create ordering races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Iteration counter: cleared in INIT, advanced once per SHIFT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_INIT:  r_cnt <= '0;
                S_SHIFT: r_cnt <= w_cnt_inc;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Next-state selection and Moore output decode.
    // NOTE: every output and the next state get a default before the case,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        ResetA       = 1'b0;
        CargaA       = 1'b0;
        DesplazaA    = 1'b0;
        CargaQ       = 1'b0;
        DesplazaQ    = 1'b0;
        CargaM       = 1'b0;
        SumaResta    = 1'b0;
        busy         = 1'b1;
        fin          = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = S_INIT;
                end
            end

            S_INIT: begin
                ResetA       = 1'b1;
                CargaQ       = 1'b1;
                CargaM       = 1'b1;
                w_state_next = S_TEST;
            end

            // Booth recoding on (Q[0], Q[-1]): 10 subtracts M, 01 adds M,
            // 00/11 only shift.
            S_TEST: begin
                case ({q0, qm1})
                    2'b10:   w_state_next = S_SUB;
                    2'b01:   w_state_next = S_ADD;
                    default: w_state_next = S_SHIFT;
                endcase
            end

            S_ADD: begin
                CargaA       = 1'b1;
                SumaResta    = 1'b0;
                w_state_next = S_SHIFT;
            end

            S_SUB: begin
                CargaA       = 1'b1;
                SumaResta    = 1'b1;
                w_state_next = S_SHIFT;
            end

            S_SHIFT: begin
                DesplazaA    = 1'b1;
                DesplazaQ    = 1'b1;
                w_state_next = w_last_iter ? S_DONE : S_TEST;
            end

            S_DONE: begin
                fin          = 1'b1;
                w_state_next = S_IDLE;
            end

            default: begin
                busy         = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// Testbench for booth_ctrl: a small A/Q/M datapath model closes the loop
// on q0/qm1, and directed scenarios check strobe sequences, latency and the
// final product against hand-computed values.

module tb_booth_ctrl;

    localparam int N = 4;

    // Output vector order: {ResetA,CargaA,DesplazaA,CargaQ,DesplazaQ,CargaM,SumaResta,busy,fin}
    localparam logic [8:0] V_IDLE  = 9'b000000000;
    localparam logic [8:0] V_INIT  = 9'b100101010;
    localparam logic [8:0] V_TEST  = 9'b000000010;
    localparam logic [8:0] V_ADD   = 9'b010000010;
    localparam logic [8:0] V_SUB   = 9'b010000110;
    localparam logic [8:0] V_SHIFT = 9'b001010010;
    localparam logic [8:0] V_DONE  = 9'b000000011;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic q0, qm1;
    logic ResetA, CargaA, DesplazaA, CargaQ, DesplazaQ, CargaM, SumaResta, busy, fin;

    logic [8:0] vec;

    // Bench datapath model and operand bus.
    logic [N-1:0] m_bus = '0;
    logic [N-1:0] q_bus = '0;
    logic [N-1:0] dp_a  = '0;
    logic [N-1:0] dp_q  = '0;
    logic [N-1:0] dp_m  = '0;
    logic         dp_qm1 = 1'b0;

    // Random q0/qm1 source used by the exclusivity run.
    logic rand_mode = 1'b0;
    logic r_q0  = 1'b0;
    logic r_qm1 = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0] obs [0:63];
    int arith_cnt;
    int sub_cnt;
    int excl_err;
    int exp_arith;

    booth_ctrl #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .q0        (q0),
        .qm1       (qm1),
        .ResetA    (ResetA),
        .CargaA    (CargaA),
        .DesplazaA (DesplazaA),
        .CargaQ    (CargaQ),
        .DesplazaQ (DesplazaQ),
        .CargaM    (CargaM),
        .SumaResta (SumaResta),
        .busy      (busy),
        .fin       (fin)
    );

    always #5 clk = ~clk;

    assign vec = {ResetA, CargaA, DesplazaA, CargaQ, DesplazaQ, CargaM, SumaResta, busy, fin};
    assign q0  = rand_mode ? r_q0  : dp_q[0];
    assign qm1 = rand_mode ? r_qm1 : dp_qm1;

    // Register file driven by the controller strobes.
    always_ff @(posedge clk) begin
        if (ResetA) begin
            dp_a   <= '0;
            dp_qm1 <= 1'b0;
        end
        if (CargaQ) dp_q <= q_bus;
        if (CargaM) dp_m <= m_bus;
        if (CargaA) dp_a <= SumaResta ? (dp_a - dp_m) : (dp_a + dp_m);
        if (DesplazaA) begin
            dp_a   <= {dp_a[N-1], dp_a[N-1:1]};
            dp_q   <= {dp_a[0], dp_q[N-1:1]};
            dp_qm1 <= dp_q[0];
        end
    end

    // One operation from IDLE; obs[c] holds the outputs in cycle c.
    // Returns latency to fin (0 on timeout). Optional start pulse at pulse_at.
    task automatic run_op(input logic [N-1:0] m_val, input logic [N-1:0] q_val,
                          input int pulse_at, output int lat);
        int cyc;
        m_bus = m_val;
        q_bus = q_val;
        arith_cnt = 0;
        sub_cnt   = 0;
        excl_err  = 0;
        exp_arith = 0;
        lat       = 0;
        for (int i = 0; i < 64; i++) obs[i] = 'x;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 40) begin
            obs[cyc] = vec;
            if ((CargaA && DesplazaA) || (CargaQ && DesplazaQ)) excl_err++;
            if (CargaA) arith_cnt++;
            if (CargaA && SumaResta) sub_cnt++;
            if (rand_mode) begin
                r_q0  = 1'($urandom_range(0, 1));
                r_qm1 = 1'($urandom_range(0, 1));
                if (vec == V_TEST && (r_q0 != r_qm1)) exp_arith++;
            end
            if (fin) begin
                lat = cyc;
                break;
            end
            start = (cyc == pulse_at);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (lat == 0) $display("FAIL run_op timeout: no fin within %0d cycles", cyc);
    endtask

    task automatic test_reset();
        int k;
        reset = 1'b0;
        #1;
        tests_run++;
        if (vec !== V_IDLE) begin
            tests_failed++;
            $display("FAIL reset_initial: outputs=%b expected=%b", vec, V_IDLE);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests_run++;
            if (vec !== V_IDLE) begin
                tests_failed++;
                $display("FAIL reset_release_idle c%0d: outputs=%b expected=%b", c, vec, V_IDLE);
            end
        end
        // Abort mid-operation while in ADD (M=3, Q=0101 reaches ADD in cycle 6).
        m_bus = 4'd3;
        q_bus = 4'b0101;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(vec == V_ADD) && k < 30) begin
            @(negedge clk);
            k++;
        end
        tests_run++;
        if (vec !== V_ADD) begin
            tests_failed++;
            $display("FAIL reset_reach_add: outputs=%b expected=%b", vec, V_ADD);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (vec !== V_IDLE) begin
            tests_failed++;
            $display("FAIL reset_mid_add_async: outputs=%b expected=%b", vec, V_IDLE);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests_run++;
            if (vec !== V_IDLE) begin
                tests_failed++;
                $display("FAIL reset_after_abort c%0d: outputs=%b expected=%b", c, vec, V_IDLE);
            end
        end
    endtask

    task automatic test_zero_multiplier();
        int lat;
        logic [8:0] exp_seq [1:10];
        exp_seq[1] = V_INIT;
        for (int i = 0; i < 4; i++) begin
            exp_seq[2 + 2*i] = V_TEST;
            exp_seq[3 + 2*i] = V_SHIFT;
        end
        exp_seq[10] = V_DONE;
        run_op(4'd5, 4'b0000, 0, lat);
        tests_run++;
        if (lat !== 10) begin
            tests_failed++;
            $display("FAIL zero_latency: got=%0d expected=10", lat);
        end
        for (int c = 1; c <= 10; c++) begin
            tests_run++;
            if (obs[c] !== exp_seq[c]) begin
                tests_failed++;
                $display("FAIL zero_seq c%0d: outputs=%b expected=%b", c, obs[c], exp_seq[c]);
            end
        end
        tests_run++;
        if (arith_cnt !== 0) begin
            tests_failed++;
            $display("FAIL zero_no_carga_a: CargaA cycles=%0d expected=0", arith_cnt);
        end
        tests_run++;
        if ({dp_a, dp_q} !== 8'h00) begin
            tests_failed++;
            $display("FAIL zero_product: got=%h expected=00", {dp_a, dp_q});
        end
    endtask

    task automatic test_worst_case();
        int lat;
        logic [8:0] exp_seq [1:14];
        exp_seq = '{V_INIT, V_TEST, V_SUB, V_SHIFT, V_TEST, V_ADD, V_SHIFT,
                    V_TEST, V_SUB, V_SHIFT, V_TEST, V_ADD, V_SHIFT, V_DONE};
        run_op(4'd3, 4'b0101, 0, lat);
        tests_run++;
        if (lat !== 14) begin
            tests_failed++;
            $display("FAIL worst_latency: got=%0d expected=14", lat);
        end
        for (int c = 1; c <= 14; c++) begin
            tests_run++;
            if (obs[c] !== exp_seq[c]) begin
                tests_failed++;
                $display("FAIL worst_seq c%0d: outputs=%b expected=%b", c, obs[c], exp_seq[c]);
            end
        end
        tests_run++;
        if ({dp_a, dp_q} !== 8'h0F) begin
            tests_failed++;
            $display("FAIL worst_product: got=%h expected=0f", {dp_a, dp_q});
        end
        // Product must persist after DONE until the next INIT.
        repeat (3) @(negedge clk);
        tests_run++;
        if ({dp_a, dp_q} !== 8'h0F) begin
            tests_failed++;
            $display("FAIL worst_product_hold: got=%h expected=0f", {dp_a, dp_q});
        end
    endtask

    task automatic test_signed();
        int lat;
        run_op(4'b0011, 4'b1110, 0, lat);
        tests_run++;
        if ({dp_a, dp_q} !== 8'hFA) begin
            tests_failed++;
            $display("FAIL signed_product: got=%h expected=fa", {dp_a, dp_q});
        end
        tests_run++;
        if (sub_cnt !== 1 || arith_cnt !== 1) begin
            tests_failed++;
            $display("FAIL signed_sumaresta: sub=%0d arith=%0d expected sub=1 arith=1", sub_cnt, arith_cnt);
        end
        tests_run++;
        if (lat !== 11) begin
            tests_failed++;
            $display("FAIL signed_latency: got=%0d expected=11", lat);
        end
    endtask

    task automatic test_back_to_back();
        m_bus = 4'd3;
        q_bus = 4'b0000;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            @(posedge clk);
            @(negedge clk);
            obs[c] = vec;
            if (c == 21) start = 1'b0;
        end
        tests_run++;
        if (obs[10] !== V_DONE) begin
            tests_failed++;
            $display("FAIL b2b_done1: outputs=%b expected=%b", obs[10], V_DONE);
        end
        tests_run++;
        if (obs[11] !== V_IDLE) begin
            tests_failed++;
            $display("FAIL b2b_idle_gap: outputs=%b expected=%b", obs[11], V_IDLE);
        end
        tests_run++;
        if (obs[12] !== V_INIT) begin
            tests_failed++;
            $display("FAIL b2b_init2: outputs=%b expected=%b", obs[12], V_INIT);
        end
        tests_run++;
        if (obs[21] !== V_DONE) begin
            tests_failed++;
            $display("FAIL b2b_done2: outputs=%b expected=%b", obs[21], V_DONE);
        end
        tests_run++;
        if (obs[23] !== V_IDLE) begin
            tests_failed++;
            $display("FAIL b2b_stop: outputs=%b expected=%b", obs[23], V_IDLE);
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        run_op(4'd3, 4'b0000, 4, lat);
        tests_run++;
        if (lat !== 10) begin
            tests_failed++;
            $display("FAIL busy_pulse_latency: got=%0d expected=10", lat);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (vec !== V_IDLE) begin
                tests_failed++;
                $display("FAIL busy_pulse_no_restart c%0d: outputs=%b expected=%b", c, vec, V_IDLE);
            end
        end
    endtask

    task automatic test_exclusivity();
        int lat;
        int exp_lat;
        rand_mode = 1'b1;
        for (int op = 0; op < 1000; op++) begin
            run_op(4'd0, 4'd0, 0, lat);
            exp_lat = 2*N + 2 + exp_arith;
            tests_run++;
            if (excl_err !== 0) begin
                tests_failed++;
                $display("FAIL excl op%0d: overlapping strobe cycles=%0d expected=0", op, excl_err);
            end
            tests_run++;
            if (lat !== exp_lat) begin
                tests_failed++;
                $display("FAIL excl_latency op%0d: got=%0d expected=%0d", op, lat, exp_lat);
            end
            tests_run++;
            if (lat < 2*N + 2 || lat > 3*N + 2) begin
                tests_failed++;
                $display("FAIL excl_latency_range op%0d: got=%0d expected within [%0d,%0d]",
                         op, lat, 2*N + 2, 3*N + 2);
            end
        end
        rand_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_multiplier();
        test_worst_case();
        test_signed();
        test_back_to_back();
        test_start_while_busy();
        test_exclusivity();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
